// File: rtl/mdu_unit_pkg.sv
// Purpose: shared op encodings and widths for the multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_unit_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

endpackage

// File: rtl/mdu_div.sv
// Purpose: combinational signed/unsigned divide, truncating toward zero, with zero/overflow cases.
// Latency: combinational.
// Backpressure: none.
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] int_min;

    always_comb begin
        int_min = {1'b1, {(WIDTH-1){1'b0}}};
        neg_a   = is_signed & a[WIDTH-1];
        neg_b   = is_signed & b[WIDTH-1];
        mag_a   = neg_a ? -a : a;
        mag_b   = neg_b ? -b : b;
        // divisor forced non-zero so the divider never sees x/0
        divisor = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quo     = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem     = neg_a ? -r_mag : r_mag;
        if (b == '0) begin
            quo = '1;
            rem = a;
        end else if (is_signed && (a == int_min) && (b == '1)) begin
            quo = a;
            rem = '0;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Purpose: MULT/MULTU/DIV/DIVU over fixed latency plus MTHI/MTLO, holding architectural HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES edges to commit with a done pulse; MTHI/MTLO one edge.
// Backpressure: busy high while an op is in flight; starts seen while busy are dropped.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic                flush,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_op_e            op_e;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               completing;
    logic               accept;

    assign op_e = mdu_op_e'(op);

    always_comb begin
        prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    mdu_div #(.WIDTH(WIDTH)) u_div (
        .is_signed (op_e == MDU_DIV),
        .a         (a),
        .b         (b),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // the completion edge frees the unit, so a new op may be accepted on it
    assign completing = busy && (cnt == CNT_W'(1));
    assign accept     = start && !flush && (!busy || completing);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (completing) begin
                hi   <= pend_hi;
                lo   <= pend_lo;
                done <= 1'b1;
                busy <= 1'b0;
                cnt  <= '0;
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (accept) begin
                case (op_e)
                    MDU_MULT: begin
                        {pend_hi, pend_lo} <= prod_s;
                        cnt  <= CNT_W'(MULT_CYCLES);
                        busy <= 1'b1;
                    end
                    MDU_MULTU: begin
                        {pend_hi, pend_lo} <= prod_u;
                        cnt  <= CNT_W'(MULT_CYCLES);
                        busy <= 1'b1;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        pend_hi <= div_rem;
                        pend_lo <= div_quo;
                        cnt     <= CNT_W'(DIV_CYCLES);
                        busy    <= 1'b1;
                    end
                    // a move accepted on a completion edge is younger, so it wins
                    MDU_MTHI: hi <= a;
                    MDU_MTLO: lo <= a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit at WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [2:0] OP_NOP = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one-cycle start pulse; returns #1 after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0; op = OP_NOP;
    endtask

    // busy must stay high n-1 more edges, then done pulses with busy low
    task automatic wait_done(input string tag, input int n);
        chk({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, " busy mid"}, {30'd0, busy, done}, 32'd2);
        end
        tick();
        chk({tag, " done"}, {30'd0, busy, done}, 32'd1);
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = OP_NOP; flush = 1'b0; a = '0; b = '0;
        #1;
        chk_hilo("reset", 32'h0, 32'h0);
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1. multiply
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult", 5);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();
        chk("done one cycle", {31'd0, done}, 32'd0);
        issue(OP_MULTU, 32'hFFFF_FFFD, 32'd5);
        wait_done("multu", 5);
        chk_hilo("multu", 32'h0000_0004, 32'hFFFF_FFF1);

        // 2. divide
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done("divu", 10);
        chk_hilo("divu 7/2", 32'd1, 32'd3);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 10);
        chk_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done("div", 10);
        chk_hilo("div -7/-2", 32'hFFFF_FFFF, 32'd3);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div", 10);
        chk_hilo("div ovf", 32'h0, 32'h8000_0000);

        // 3. divide by zero and moves
        issue(OP_DIV, 32'd9, 32'd0);
        wait_done("div0", 10);
        chk_hilo("div 9/0", 32'd9, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'h8000_0010, 32'd0);
        wait_done("divu0", 10);
        chk_hilo("divu x/0", 32'h8000_0010, 32'hFFFF_FFFF);
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi hi", hi, 32'h0000_1234);
        chk("mthi busy/done", {30'd0, busy, done}, 32'd0);
        issue(OP_MTLO, 32'h0000_0055, 32'd0);
        chk_hilo("mtlo", 32'h0000_1234, 32'h0000_0055);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        chk_hilo("reserved", 32'h0000_1234, 32'h0000_0055);

        // 4. start while busy is dropped; start on completion edge is accepted
        issue(OP_DIV, 32'd100, 32'd7);
        tick();
        tick();
        issue(OP_MULT, 32'd6, 32'd7);
        chk("ignored busy", {30'd0, busy, done}, 32'd2);
        for (int i = 4; i < 10; i++) tick();
        start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
        tick();
        start = 1'b0; op = OP_NOP;
        chk("b2b done+busy", {30'd0, busy, done}, 32'd3);
        chk_hilo("div 100/7", 32'd2, 32'd14);
        for (int i = 1; i < 5; i++) tick();
        chk("b2b pre", {30'd0, busy, done}, 32'd2);
        tick();
        chk("b2b done", {30'd0, busy, done}, 32'd1);
        chk_hilo("mult 6*7", 32'd0, 32'd42);

        // 5. flush mid-op, flush vs start, flush on completion edge
        issue(OP_MULT, 32'd3, 32'd3);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy/done", {30'd0, busy, done}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("flush no done", {31'd0, done}, 32'd0);
        chk_hilo("flush keep", 32'd0, 32'd42);
        flush = 1'b1;
        issue(OP_MTHI, 32'hDEAD_0000, 32'd0);
        flush = 1'b0;
        chk("flush>start", hi, 32'd0);
        issue(OP_MULT, 32'd2, 32'd2);
        for (int i = 1; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush@done", {30'd0, busy, done}, 32'd0);
        tick();
        chk("flush@done later", {30'd0, busy, done}, 32'd0);
        chk_hilo("flush@done keep", 32'd0, 32'd42);

        // 6. asynchronous reset mid-divide
        issue(OP_DIV, 32'd50, 32'd5);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_hilo("async rst", 32'd0, 32'd0);
        chk("async rst busy/done", {30'd0, busy, done}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        issue(OP_MULT, 32'd7, 32'd8);
        wait_done("post-rst mult", 5);
        chk_hilo("post-rst mult", 32'd0, 32'd56);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
